// File: rtl/decode_pkg.sv
// Shared types and helpers for the decode stage: opcode set, immediate formats
// and the per-opcode decode table.
package decode_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_IMM    = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111
    } opcode_e;

    typedef enum logic [2:0] {
        IMM_R,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // Which register fields an opcode really uses; unused fields carry
    // immediate bits and must not raise an index error.
    typedef struct packed {
        logic     legal;
        imm_fmt_e fmt;
        logic     use_rs1;
        logic     use_rs2;
        logic     use_rd;
    } op_info_t;

    function automatic op_info_t op_decode(input logic [6:0] op);
        op_info_t info;
        info = '{legal: 1'b0, fmt: IMM_R, use_rs1: 1'b0, use_rs2: 1'b0, use_rd: 1'b0};
        case (op)
            OP_R:      info = '{1'b1, IMM_R, 1'b1, 1'b1, 1'b1};
            OP_IMM:    info = '{1'b1, IMM_I, 1'b1, 1'b0, 1'b1};
            OP_LOAD:   info = '{1'b1, IMM_I, 1'b1, 1'b0, 1'b1};
            OP_JALR:   info = '{1'b1, IMM_I, 1'b1, 1'b0, 1'b1};
            OP_STORE:  info = '{1'b1, IMM_S, 1'b1, 1'b1, 1'b0};
            OP_BRANCH: info = '{1'b1, IMM_B, 1'b1, 1'b1, 1'b0};
            OP_LUI:    info = '{1'b1, IMM_U, 1'b0, 1'b0, 1'b1};
            OP_AUIPC:  info = '{1'b1, IMM_U, 1'b0, 1'b0, 1'b1};
            OP_JAL:    info = '{1'b1, IMM_J, 1'b0, 1'b0, 1'b1};
            default:   info = '{1'b0, IMM_R, 1'b0, 1'b0, 1'b0};
        endcase
        return info;
    endfunction

    // 32-bit signed immediate; wider datapaths sign-extend the result.
    function automatic logic [31:0] imm_gen(input logic [31:0] komut, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{komut[31]}}, komut[31:20]};
            IMM_S:   imm = {{20{komut[31]}}, komut[31:25], komut[11:7]};
            IMM_B:   imm = {{19{komut[31]}}, komut[31], komut[7], komut[30:25], komut[11:8], 1'b0};
            IMM_U:   imm = {komut[31:12], 12'b0};
            IMM_J:   imm = {{11{komut[31]}}, komut[31], komut[19:12], komut[20], komut[30:21], 1'b0};
            default: imm = 32'b0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_if.sv
// Bundle of fetch-side, execute-side and write-back signals of the decode stage.
interface decode_if #(
    parameter int XLEN = 32
);
    import decode_pkg::*;

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // Valid never waits for ready; a producer holding valid keeps its payload
    // stable until the transfer. in_ready = !out_valid || out_ready.
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          komut;
    logic [XLEN-1:0]      in_pc;
    logic                 flush;

    logic                 out_valid;
    logic                 out_ready;
    logic [6:0]           opcode;
    logic [3:0]           func;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      rs1_data;
    logic [XLEN-1:0]      rs2_data;
    logic [XLEN-1:0]      imm;
    logic [XLEN-1:0]      out_pc;
    logic                 hata;

    logic                 we;
    logic [REG_IDX_W-1:0] wb_rd;
    logic [XLEN-1:0]      rd_data;

    modport master (
        output in_valid, komut, in_pc, flush, out_ready, we, wb_rd, rd_data,
        input  in_ready, out_valid, opcode, func, rd, rs1_data, rs2_data, imm, out_pc, hata
    );

    modport slave (
        input  in_valid, komut, in_pc, flush, out_ready, we, wb_rd, rd_data,
        output in_ready, out_valid, opcode, func, rd, rs1_data, rs2_data, imm, out_pc, hata
    );

endinterface

// File: rtl/decode_regfile.sv
// NREGS x XLEN architectural register file: two async reads, one sync write,
// synchronous active-low clear. x0 and out-of-range indices read as zero.
module decode_regfile
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] ra1,
    input  logic [REG_IDX_W-1:0] ra2,
    output logic [XLEN-1:0]      rd1,
    output logic [XLEN-1:0]      rd2,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] wa,
    input  logic [XLEN-1:0]      wd
);

    localparam int IDX_W = $clog2(NREGS);

    logic [XLEN-1:0] regs [NREGS];

    function automatic logic idx_live(input logic [REG_IDX_W-1:0] idx);
        return (idx != '0) && (int'(idx) < NREGS);
    endfunction

    assign rd1 = idx_live(ra1) ? regs[ra1[IDX_W-1:0]] : '0;
    assign rd2 = idx_live(ra2) ? regs[ra2[IDX_W-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && idx_live(wa)) begin
            regs[wa[IDX_W-1:0]] <= wd;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Pipelined decode stage: one-slot output register, valid/ready on both sides,
// flush, write-back port. Optional operand forwarding under DECODE_BYPASS_EN.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input logic     clk,
    input logic     reset,
    decode_if.slave bus
);

    typedef struct packed {
        logic [6:0]           opcode;
        logic [3:0]           func;
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      rs1_data;
        logic [XLEN-1:0]      rs2_data;
        logic [XLEN-1:0]      imm;
        logic [XLEN-1:0]      pc;
        logic                 hata;
    } slot_t;

    function automatic logic idx_ok(input logic [REG_IDX_W-1:0] idx);
        return int'(idx) < NREGS;
    endfunction

    logic [REG_IDX_W-1:0] rs1_idx;
    logic [REG_IDX_W-1:0] rs2_idx;
    logic [REG_IDX_W-1:0] rd_idx;
    op_info_t             info;
    logic                 bad_idx;
    logic [XLEN-1:0]      imm_ext;
    logic [XLEN-1:0]      rf_rs1;
    logic [XLEN-1:0]      rf_rs2;
    logic [XLEN-1:0]      rs1_fwd;
    logic [XLEN-1:0]      rs2_fwd;
    logic                 in_ready;
    logic                 load;
    logic                 out_valid_q;
    slot_t                slot_d;
    slot_t                slot_q;

    assign rs1_idx = bus.komut[19:15];
    assign rs2_idx = bus.komut[24:20];
    assign rd_idx  = bus.komut[11:7];
    assign info    = op_decode(bus.komut[6:0]);

    assign bad_idx = (info.use_rs1 && !idx_ok(rs1_idx)) ||
                     (info.use_rs2 && !idx_ok(rs2_idx)) ||
                     (info.use_rd  && !idx_ok(rd_idx));

    assign imm_ext = XLEN'($signed(imm_gen(bus.komut, info.fmt)));

    decode_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk   (clk),
        .reset (reset),
        .ra1   (rs1_idx),
        .ra2   (rs2_idx),
        .rd1   (rf_rs1),
        .rd2   (rf_rs2),
        .we    (bus.we),
        .wa    (bus.wb_rd),
        .wd    (bus.rd_data)
    );

`ifdef DECODE_BYPASS_EN
    logic                 wb_hit;
    logic [REG_IDX_W-1:0] rs1_idx_q;
    logic [REG_IDX_W-1:0] rs2_idx_q;

    // Mirrors the register file's own write qualification, so a forwarded
    // value is always one that is really being committed this edge.
    assign wb_hit  = bus.we && (bus.wb_rd != '0) && idx_ok(bus.wb_rd);
    assign rs1_fwd = (wb_hit && (bus.wb_rd == rs1_idx)) ? bus.rd_data : rf_rs1;
    assign rs2_fwd = (wb_hit && (bus.wb_rd == rs2_idx)) ? bus.rd_data : rf_rs2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rs1_idx_q <= '0;
            rs2_idx_q <= '0;
        end else if (load) begin
            rs1_idx_q <= rs1_idx;
            rs2_idx_q <= rs2_idx;
        end
    end
`else
    assign rs1_fwd = rf_rs1;
    assign rs2_fwd = rf_rs2;
`endif

    assign in_ready = !out_valid_q || bus.out_ready;
    assign load     = bus.in_valid && in_ready && !bus.flush;

    always_comb begin
        slot_d          = '0;
        slot_d.opcode   = bus.komut[6:0];
        slot_d.func     = {bus.komut[30], bus.komut[14:12]};
        slot_d.rd       = rd_idx;
        slot_d.rs1_data = rs1_fwd;
        slot_d.rs2_data = rs2_fwd;
        slot_d.imm      = imm_ext;
        slot_d.pc       = bus.in_pc;
        slot_d.hata     = !info.legal || bad_idx;
    end

    // Flush only kills validity; the held payload is don't-care afterwards.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            slot_q      <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            slot_q      <= slot_d;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
`ifdef DECODE_BYPASS_EN
        else if (out_valid_q && wb_hit) begin
            if (bus.wb_rd == rs1_idx_q) slot_q.rs1_data <= bus.rd_data;
            if (bus.wb_rd == rs2_idx_q) slot_q.rs2_data <= bus.rd_data;
        end
`endif
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.opcode    = slot_q.opcode;
    assign bus.func      = slot_q.func;
    assign bus.rd        = slot_q.rd;
    assign bus.rs1_data  = slot_q.rs1_data;
    assign bus.rs2_data  = slot_q.rs2_data;
    assign bus.imm       = slot_q.imm;
    assign bus.out_pc    = slot_q.pc;
    assign bus.hata      = slot_q.hata;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with NREGS=16; expected slots are queued at
// acceptance and checked by an independent monitor when execute takes them.
module tb_decode_stage;

    localparam int XLEN  = 32;
    localparam int NREGS = 16;
    localparam int W     = 7 + 4 + 5 + 4 * 32 + 1;
`ifdef DECODE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;
    logic [W-1:0] e_a;
    logic [31:0]  burst_k [11];
    logic [W-1:0] burst_e [11];

    always #5 clk = ~clk;

    decode_if #(.XLEN(XLEN)) bus ();

    decode_stage #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [W-1:0] mk(input logic [6:0] op, input logic [3:0] fn,
                                        input logic [4:0] rd, input logic [31:0] r1,
                                        input logic [31:0] r2, input logic [31:0] im,
                                        input logic [31:0] pc, input logic h);
        return {op, fn, rd, r1, r2, im, pc, h};
    endfunction

    function automatic logic [W-1:0] act();
        return {bus.opcode, bus.func, bus.rd, bus.rs1_data, bus.rs2_data,
                bus.imm, bus.out_pc, bus.hata};
    endfunction

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: a slot leaves on every edge where valid && ready.
    always @(negedge clk) begin
        if (reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL slot_unexpected got=%0h expected=none", act());
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("slot_pc%0h", mon_e[32:1]), act(), mon_e);
            end
        end
    end

    task automatic send(input logic [31:0] k, input logic [31:0] pc, input logic [W-1:0] e);
        bit acc;
        bit done;
        int n;
        done = 1'b0;
        n = 0;
        bus.komut    = k;
        bus.in_pc    = pc;
        bus.in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            acc = bus.in_ready && !bus.flush;
            @(posedge clk);
            if (acc) begin
                exp_q.push_back(e);
                done = 1'b1;
            end else if (++n > 50) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_timeout got=stalled expected=accept pc=%0h", pc);
                done = 1'b1;
            end
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] idx, input logic [31:0] d);
        bus.we      = 1'b1;
        bus.wb_rd   = idx;
        bus.rd_data = d;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
    endtask

    initial begin
        #100000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog got=timeout expected=finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b1;
        bus.komut     = 32'h0000_0013;
        bus.in_pc     = 32'h0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        bus.we        = 1'b0;
        bus.wb_rd     = 5'd0;
        bus.rd_data   = 32'h0;

        // Reset with a live request on the input.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", W'(bus.out_valid), W'(0));
        check("rst_in_ready", W'(bus.in_ready), W'(1));
        check("rst_outputs", act(), '0);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;

        wb(5'd5, 32'h0000_0064);
        wb(5'd1, 32'h0000_0011);
        wb(5'd2, 32'h0000_0022);

        // addi x6,x5,20; rs2 field 20 is out of range but unused by I-type.
        e_a = mk(7'h13, 4'h0, 5'd6, 32'h64, 32'h0, 32'h14, 32'h100, 1'b0);
        send(32'h0142_8313, 32'h100, e_a);
        check("load_valid", W'(bus.out_valid), W'(1));

        bus.out_ready = 1'b0;
        bus.komut     = 32'h0022_A423;
        bus.in_pc     = 32'h104;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", W'(bus.in_ready), W'(0));
            check("stall_hold", act(), e_a);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;

        burst_k[0]  = 32'h0022_A423;
        burst_e[0]  = mk(7'h23, 4'h2, 5'd8,  32'h64, 32'h22, 32'h8,        32'h104, 1'b0);
        burst_k[1]  = 32'hFE20_8EE3;
        burst_e[1]  = mk(7'h63, 4'h8, 5'd29, 32'h11, 32'h22, 32'hFFFF_FFFC, 32'h108, 1'b0);
        burst_k[2]  = 32'h1234_53B7;
        burst_e[2]  = mk(7'h37, 4'h5, 5'd7,  32'h0,  32'h0,  32'h1234_5000, 32'h10C, 1'b0);
        burst_k[3]  = 32'hFF9F_F0EF;
        burst_e[3]  = mk(7'h6F, 4'hF, 5'd1,  32'h0,  32'h0,  32'hFFFF_FFF8, 32'h110, 1'b0);
        burst_k[4]  = 32'h0000_007F;
        burst_e[4]  = mk(7'h7F, 4'h0, 5'd0,  32'h0,  32'h0,  32'h0,        32'h114, 1'b1);
        burst_k[5]  = 32'h01F0_0093;
        burst_e[5]  = mk(7'h13, 4'h0, 5'd1,  32'h0,  32'h0,  32'h1F,       32'h118, 1'b0);
        burst_k[6]  = 32'h0028_81B3;
        burst_e[6]  = mk(7'h33, 4'h0, 5'd3,  32'h0,  32'h22, 32'h0,        32'h11C, 1'b1);
        burst_k[7]  = 32'h4011_0233;
        burst_e[7]  = mk(7'h33, 4'h8, 5'd4,  32'h22, 32'h11, 32'h0,        32'h120, 1'b0);
        burst_k[8]  = 32'hFFFF_F497;
        burst_e[8]  = mk(7'h17, 4'hF, 5'd9,  32'h0,  32'h0,  32'hFFFF_F000, 32'h124, 1'b0);
        burst_k[9]  = 32'hFFF2_A503;
        burst_e[9]  = mk(7'h03, 4'hA, 5'd10, 32'h64, 32'h0,  32'hFFFF_FFFF, 32'h128, 1'b0);
        burst_k[10] = 32'h0000_8067;
        burst_e[10] = mk(7'h67, 4'h0, 5'd0,  32'h11, 32'h0,  32'h0,        32'h12C, 1'b0);
        for (int i = 0; i < 11; i++) begin
            send(burst_k[i], 32'h104 + 32'(4 * i), burst_e[i]);
            check("burst_valid", W'(bus.out_valid), W'(1));
        end

        // Flush a stalled slot while fetch offers a new word.
        send(32'h0050_0313, 32'h200, mk(7'h13, 4'h0, 5'd6, 32'h0, 32'h64, 32'h5, 32'h200, 1'b0));
        bus.out_ready = 1'b0;
        bus.komut     = 32'h0010_006F;
        bus.in_pc     = 32'h204;
        bus.in_valid  = 1'b1;
        bus.flush     = 1'b1;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        void'(exp_q.pop_back());
        check("flush_stalled", W'(bus.out_valid), W'(0));
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("flush_dropped", W'(bus.out_valid), W'(0));
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_idle", W'(bus.out_valid), W'(0));

        // Write-back coinciding with the load of add x3,x1,x2.
        bus.we      = 1'b1;
        bus.wb_rd   = 5'd1;
        bus.rd_data = 32'hA5A5_A5A5;
        send(32'h0020_81B3, 32'h300,
             mk(7'h33, 4'h0, 5'd3, BYP ? 32'hA5A5_A5A5 : 32'h11, 32'h22, 32'h0, 32'h300, 1'b0));
        bus.we = 1'b0;

        // Write-back to x2 while the slot reading x2 is stalled.
        send(32'h0020_81B3, 32'h304,
             mk(7'h33, 4'h0, 5'd3, 32'hA5A5_A5A5, BYP ? 32'h5A5A_5A5A : 32'h22, 32'h0, 32'h304, 1'b0));
        bus.out_ready = 1'b0;
        wb(5'd2, 32'h5A5A_5A5A);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;

        wb(5'd0, 32'hFFFF_FFFF);
        wb(5'd20, 32'hDEAD_BEEF);
        send(32'h0000_02B3, 32'h308, mk(7'h33, 4'h0, 5'd5, 32'h0, 32'h0, 32'h0, 32'h308, 1'b0));
        send(32'h0002_0333, 32'h30C, mk(7'h33, 4'h0, 5'd6, 32'h0, 32'h0, 32'h0, 32'h30C, 1'b0));
        send(32'h0001_03B3, 32'h310, mk(7'h33, 4'h0, 5'd7, 32'h5A5A_5A5A, 32'h0, 32'h0, 32'h310, 1'b0));

        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        check("queue_empty", W'(exp_q.size()), W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
